// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and helpers for the two-requester RC mux arbiter.
// Optional max-hold preemption is enabled by MUX_ARB_MAXHOLD_EN.
package mux_arb_pkg;

  localparam int MUX_ARB_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } mux_arb_state_t;

  // Single request wins outright; a tie goes to the side not served last.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       last
  );
    return (&req) ? ~last : req[1];
  endfunction

  function automatic logic [1:0] sel2gnt(
    input logic sel
  );
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between requesters and the mux arbiter.
// The arbiter takes the slave view; requesters take the master view.
interface mux_sel_arbiter_if;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       sel_valid;
  logic       busy;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  sel_valid,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output sel_valid,
    output busy
  );

endinterface

// File: rtl/mux_sel_arbiter_timer.sv
// Load/decrement down-counter; done flags an enabled count at zero.
// Used for the settle window and, with MUX_ARB_MAXHOLD_EN, hold limit.
module mux_settle_timer
  import mux_arb_pkg::*;
#(
  parameter int W = MUX_ARB_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= ld_val;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = en && (cnt_q == '0);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter and settle sequencer owning the RC mux SEL line.
// Define MUX_ARB_MAXHOLD_EN to enable max-hold grant preemption.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int MAX_HOLD   = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux_sel_arbiter_if.slave    bus
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("SETTLE_CYC out of range 1..255");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 1..255");
  end

  localparam logic [MUX_ARB_CNT_W-1:0] SET_LD =
    MUX_ARB_CNT_W'(SETTLE_CYC - 1);

  mux_arb_state_t state_q;
  logic [1:0]     gnt_q;
  logic           sel_q;
  logic           settled_q;
  logic           last_q;

  logic [1:0] req;
  logic       win;
  logic       cur;
  logic       oth;
  logic       to_settle;
  logic       to_grant;
  logic       set_done;

  assign req = bus.req;
  assign win = rr_pick(req, last_q);
  assign cur = req[sel_q];
  assign oth = req[~sel_q];

  mux_settle_timer #(
    .W (MUX_ARB_CNT_W)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (to_settle),
    .en     (state_q == SETTLE),
    .ld_val (SET_LD),
    .done   (set_done)
  );

`ifdef MUX_ARB_MAXHOLD_EN
  localparam logic [MUX_ARB_CNT_W-1:0] HOLD_LD =
    MUX_ARB_CNT_W'(MAX_HOLD - 1);

  logic hold_done;

  // Reloaded on every GRANT entry; reaching zero means MAX_HOLD cycles served.
  mux_settle_timer #(
    .W (MUX_ARB_CNT_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (to_grant),
    .en     (state_q == GRANT),
    .ld_val (HOLD_LD),
    .done   (hold_done)
  );
`endif

  always_comb begin
    to_settle = 1'b0;
    to_grant  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          if (settled_q && sel_q == win) begin
            to_grant = 1'b1;
          end else begin
            to_settle = 1'b1;
          end
        end
      end
      SETTLE: begin
        to_grant = cur && set_done;
      end
      GRANT: begin
`ifdef MUX_ARB_MAXHOLD_EN
        to_settle = oth && (!cur || hold_done);
`else
        to_settle = oth && !cur;
`endif
      end
      default: begin
        to_settle = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      sel_q     <= 1'b0;
      settled_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (to_grant) begin
            state_q <= GRANT;
            gnt_q   <= sel2gnt(sel_q);
            last_q  <= sel_q;
          end else if (to_settle) begin
            state_q   <= SETTLE;
            sel_q     <= win;
            settled_q <= 1'b0;
          end
        end
        SETTLE: begin
          // A vanished requester aborts before any grant can be issued.
          if (!cur) begin
            state_q <= IDLE;
          end else if (to_grant) begin
            state_q   <= GRANT;
            settled_q <= 1'b1;
            gnt_q     <= sel2gnt(sel_q);
            last_q    <= sel_q;
          end
        end
        GRANT: begin
          if (to_settle) begin
            state_q   <= SETTLE;
            gnt_q     <= 2'b00;
            sel_q     <= ~sel_q;
            settled_q <= 1'b0;
          end else if (!cur) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = settled_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (SETTLE_CYC=4, MAX_HOLD=8).
// Preemption sequence follows MUX_ARB_MAXHOLD_EN.
module tb_mux_sel_arbiter;

  localparam int SC = 4;
  localparam int MH = 8;

  typedef struct packed {
    logic [1:0] g;
    logic       s;
    logic       v;
    logic       b;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic [1:0] q;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exp_t sbq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(
    .SETTLE_CYC (SC),
    .MAX_HOLD   (MH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t ex(
    input logic [1:0] g,
    input logic s,
    input logic v,
    input logic b
  );
    exp_t e;
    e.g = g;
    e.s = s;
    e.v = v;
    e.b = b;
    return e;
  endfunction

  task automatic add(
    input logic r,
    input logic [1:0] q,
    input logic [1:0] g,
    input logic s,
    input logic v,
    input logic b
  );
    vec_t t;
    t.r = r;
    t.q = q;
    t.e = ex(g, s, v, b);
    tbl.push_back(t);
  endtask

  task automatic step(
    input logic r,
    input logic [1:0] q,
    input exp_t e,
    input string nm
  );
    exp_t x;
    exp_t a;
    @(negedge clk);
    rst = r;
    bus.req = q;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    a = {bus.gnt, bus.sel, bus.sel_valid, bus.busy};
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b vld=%b busy=%b, want gnt=%b sel=%b vld=%b busy=%b",
        nm, a.g, a.s, a.v, a.b, x.g, x.s, x.v, x.b);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 2'b00;

    // reset, then single request from reset
    add(1, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b01, 2'b00, 0, 0, 1);
    add(0, 2'b01, 2'b00, 0, 0, 1);
    add(0, 2'b01, 2'b00, 0, 0, 1);
    add(0, 2'b01, 2'b00, 0, 0, 1);
    add(0, 2'b01, 2'b01, 0, 1, 1);
    add(0, 2'b01, 2'b01, 0, 1, 1);
    add(0, 2'b00, 2'b00, 0, 1, 0);
    // fast path
    add(0, 2'b01, 2'b01, 0, 1, 1);
    add(0, 2'b00, 2'b00, 0, 1, 0);
    // abort in SETTLE
    add(0, 2'b10, 2'b00, 1, 0, 1);
    add(0, 2'b10, 2'b00, 1, 0, 1);
    add(0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b00, 2'b00, 1, 0, 0);
    // re-request takes the full settle
    add(0, 2'b10, 2'b00, 1, 0, 1);
    for (int i = 0; i < SC - 1; i++) begin
      add(0, 2'b10, 2'b00, 1, 0, 1);
    end
    add(0, 2'b10, 2'b10, 1, 1, 1);
    add(0, 2'b00, 2'b00, 1, 1, 0);
    // reset mid-SETTLE
    add(0, 2'b01, 2'b00, 0, 0, 1);
    add(0, 2'b01, 2'b00, 0, 0, 1);
    add(1, 2'b01, 2'b00, 0, 0, 0);
    // simultaneous first request, then handover
    add(1, 2'b11, 2'b00, 0, 0, 0);
    for (int i = 0; i < SC; i++) begin
      add(0, 2'b11, 2'b00, 0, 0, 1);
    end
    add(0, 2'b11, 2'b01, 0, 1, 1);
    add(0, 2'b11, 2'b01, 0, 1, 1);
    add(0, 2'b10, 2'b00, 1, 0, 1);
    for (int i = 0; i < SC - 1; i++) begin
      add(0, 2'b10, 2'b00, 1, 0, 1);
    end
    add(0, 2'b10, 2'b10, 1, 1, 1);
    add(0, 2'b00, 2'b00, 1, 1, 0);
    // ties alternate: last=1 so 0 wins, then 1 wins
    for (int i = 0; i < SC; i++) begin
      add(0, 2'b11, 2'b00, 0, 0, 1);
    end
    add(0, 2'b11, 2'b01, 0, 1, 1);
    add(0, 2'b00, 2'b00, 0, 1, 0);
    for (int i = 0; i < SC; i++) begin
      add(0, 2'b11, 2'b00, 1, 0, 1);
    end
    add(0, 2'b11, 2'b10, 1, 1, 1);
    add(0, 2'b00, 2'b00, 1, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].e,
        $sformatf("vec[%0d]", i));
    end

    // requester 0 takes the mux from sel=1
    for (int i = 0; i < SC; i++) begin
      step(0, 2'b01, ex(2'b00, 0, 0, 1), "hold_setup");
    end
    step(0, 2'b01, ex(2'b01, 0, 1, 1), "hold_gnt0");

`ifdef MUX_ARB_MAXHOLD_EN
    for (int i = 0; i < MH - 1; i++) begin
      step(0, 2'b11, ex(2'b01, 0, 1, 1), "hold_keep0");
    end
    step(0, 2'b11, ex(2'b00, 1, 0, 1), "preempt0");
    for (int i = 0; i < SC - 1; i++) begin
      step(0, 2'b11, ex(2'b00, 1, 0, 1), "preempt_settle1");
    end
    step(0, 2'b11, ex(2'b10, 1, 1, 1), "preempt_gnt1");
    for (int i = 0; i < MH - 1; i++) begin
      step(0, 2'b11, ex(2'b10, 1, 1, 1), "hold_keep1");
    end
    step(0, 2'b11, ex(2'b00, 0, 0, 1), "preempt1");
    for (int i = 0; i < SC - 1; i++) begin
      step(0, 2'b11, ex(2'b00, 0, 0, 1), "preempt_settle0");
    end
    step(0, 2'b11, ex(2'b01, 0, 1, 1), "reserve_gnt0");
`else
    for (int i = 0; i < 100; i++) begin
      step(0, 2'b11, ex(2'b01, 0, 1, 1), "no_preempt");
    end
`endif
    step(0, 2'b00, ex(2'b00, 0, 1, 0), "final_release");

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
